// File: rtl/ram_pkg.sv
// Shared definitions for the dual-port synchronous RAM: default geometry
// and the clear/ready state encoding.
package ram_pkg;

    localparam int RAM_DATA_WIDTH = 32;
    localparam int RAM_ADDR_WIDTH = 5;

    typedef logic [0:0] state_t;

    localparam state_t CLEAR = 1'b0;
    localparam state_t READY = 1'b1;

endpackage

// File: rtl/ram_dp_sync_if.sv
// Request/response bundle of the dual-port RAM: one write port, one read
// port, and the status outputs.
interface ram_dp_sync_if
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH = RAM_DATA_WIDTH,
    parameter int ADDR_WIDTH = RAM_ADDR_WIDTH
);

    logic                      ena;
    logic                      wena;
    logic [ADDR_WIDTH-1:0]     waddr;
    logic [DATA_WIDTH-1:0]     wdata;
    logic [DATA_WIDTH/8-1:0]   wbe;
    logic                      rena;
    logic [ADDR_WIDTH-1:0]     raddr;
    logic [DATA_WIDTH-1:0]     rdata;
    logic                      rvalid;
    logic                      busy;

    modport master (
        output ena, wena, waddr, wdata, wbe, rena, raddr,
        input  rdata, rvalid, busy
    );

    modport slave (
        input  ena, wena, waddr, wdata, wbe, rena, raddr,
        output rdata, rvalid, busy
    );

endinterface

// File: rtl/ram_clear_ctrl.sv
// Sequences the power-up / reset clear: walks every address once, then
// hands the array over to the user ports.
module ram_clear_ctrl
    import ram_pkg::*;
#(
    parameter int ADDR_WIDTH = RAM_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    output state_t                state,
    output logic [ADDR_WIDTH-1:0] clr_cnt,
    output logic                  busy
);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else if (state == CLEAR) begin
            clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
            // Last address is being zeroed this cycle.
            if (&clr_cnt) begin
                state <= READY;
            end
        end
    end

    assign busy = (state == CLEAR);

endmodule

// File: rtl/ram_dp_sync.sv
// Single-clock dual-port RAM with byte-lane writes, registered reads,
// selectable read-during-write behaviour and a self-clear after reset.
module ram_dp_sync
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH  = RAM_DATA_WIDTH,
    parameter int ADDR_WIDTH  = RAM_ADDR_WIDTH,
    parameter int WRITE_FIRST = 1
) (
    input  logic          clk,
    input  logic          rst,
    ram_dp_sync_if.slave  bus
);

    localparam int DEPTH  = 2 ** ADDR_WIDTH;
    localparam int NBYTES = DATA_WIDTH / 8;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   clr_cnt;
    logic                    busy;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    wr_acc;
    logic                    rd_acc;
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_waddr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [NBYTES-1:0]       mem_wbe;
    logic [DATA_WIDTH-1:0]   rd_word;
    logic [DATA_WIDTH-1:0]   rd_next;

    logic [DATA_WIDTH-1:0]   rdata_p0;
    logic                    vld_p0;

    function automatic logic [DATA_WIDTH-1:0] merge_lanes(
        input logic [DATA_WIDTH-1:0] old_w,
        input logic [DATA_WIDTH-1:0] new_w,
        input logic [NBYTES-1:0]     be
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_w;
        for (int i = 0; i < NBYTES; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end
        end
        return res;
    endfunction

    ram_clear_ctrl #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_clear (
        .clk     (clk),
        .rst     (rst),
        .state   (state),
        .clr_cnt (clr_cnt),
        .busy    (busy)
    );

    // A request coinciding with rst is dropped along with everything else.
    assign wr_acc = (state == READY) && !rst && bus.ena && bus.wena;
    assign rd_acc = (state == READY) && !rst && bus.ena && bus.rena;

    always_comb begin
        mem_we    = wr_acc;
        mem_waddr = bus.waddr;
        mem_wdata = bus.wdata;
        mem_wbe   = bus.wbe;
        if (state == CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = clr_cnt;
            mem_wdata = '0;
            mem_wbe   = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (mem_wbe[i]) begin
                    mem[mem_waddr][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end
        end
    end

    // Same-address collision: write-first forwards the enabled lanes of wdata.
    always_comb begin
        rd_word = mem[bus.raddr];
        rd_next = rd_word;
        if ((WRITE_FIRST != 0) && wr_acc && (bus.waddr == bus.raddr)) begin
            rd_next = merge_lanes(rd_word, bus.wdata, bus.wbe);
        end
    end

    // ---- stage p0: registered read result ----
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_p0 <= '0;
            vld_p0   <= 1'b0;
        end else begin
            vld_p0 <= rd_acc;
            if (rd_acc) begin
                rdata_p0 <= rd_next;
            end
        end
    end

    assign bus.rdata  = rdata_p0;
    assign bus.rvalid = vld_p0;
    assign bus.busy   = busy;

endmodule

// File: tb/tb_ram_dp_sync.sv
// Bench for ram_dp_sync: a write-first and a read-first instance share one
// stimulus stream and are checked every cycle against an array model.
module tb_ram_dp_sync;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          ena, wena, rena;
    logic [AW-1:0] waddr, raddr;
    logic [DW-1:0] wdata;
    logic [3:0]    wbe;

    int n_cmp = 0;
    int n_mis = 0;

    ram_dp_sync_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if0 ();
    ram_dp_sync_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if1 ();

    assign if0.ena = ena;   assign if1.ena = ena;
    assign if0.wena = wena; assign if1.wena = wena;
    assign if0.rena = rena; assign if1.rena = rena;
    assign if0.waddr = waddr; assign if1.waddr = waddr;
    assign if0.raddr = raddr; assign if1.raddr = raddr;
    assign if0.wdata = wdata; assign if1.wdata = wdata;
    assign if0.wbe = wbe;   assign if1.wbe = wbe;

    ram_dp_sync #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WRITE_FIRST(1)) dut_wf (
        .clk (clk), .rst (rst), .bus (if0)
    );
    ram_dp_sync #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WRITE_FIRST(0)) dut_rf (
        .clk (clk), .rst (rst), .bus (if1)
    );

    initial forever #5 clk = ~clk;

    // Model: contents, cycles since reset, and the expected read port.
    logic [DW-1:0] m_mem [2][DEPTH];
    int            m_since [2];
    logic [DW-1:0] m_rdata [2];
    logic          m_rvalid [2];
    bit            m_started = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_since[k]  = 0;
                m_rdata[k]  = '0;
                m_rvalid[k] = 1'b0;
                for (int a = 0; a < DEPTH; a++) m_mem[k][a] = '0;
                m_started = 1'b1;
            end else begin
                logic          ready;
                logic [DW-1:0] word;
                ready = (m_since[k] >= DEPTH);
                if (m_since[k] < DEPTH) m_since[k]++;
                m_rvalid[k] = 1'b0;
                if (ready && ena) begin
                    if (rena) begin
                        word = m_mem[k][raddr];
                        if (k == 0 && wena && waddr == raddr)
                            for (int b = 0; b < 4; b++)
                                if (wbe[b]) word[8*b +: 8] = wdata[8*b +: 8];
                        m_rdata[k]  = word;
                        m_rvalid[k] = 1'b1;
                    end
                    if (wena)
                        for (int b = 0; b < 4; b++)
                            if (wbe[b]) m_mem[k][waddr][8*b +: 8] = wdata[8*b +: 8];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            check("wf_busy",   32'(if0.busy),   32'(m_since[0] < DEPTH));
            check("wf_rvalid", 32'(if0.rvalid), 32'(m_rvalid[0]));
            check("wf_rdata",  if0.rdata,       m_rdata[0]);
            check("rf_busy",   32'(if1.busy),   32'(m_since[1] < DEPTH));
            check("rf_rvalid", 32'(if1.rvalid), 32'(m_rvalid[1]));
            check("rf_rdata",  if1.rdata,       m_rdata[1]);
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        ena = 1'b0; wena = 1'b0; rena = 1'b0;
        waddr = '0; raddr = '0; wdata = '0; wbe = '0;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
        idle();
        ena = 1'b1; wena = 1'b1; waddr = a; wdata = d; wbe = be;
        tick();
        idle();
    endtask

    task automatic rd(input logic [AW-1:0] a);
        idle();
        ena = 1'b1; rena = 1'b1; raddr = a;
        tick();
        idle();
    endtask

    initial begin
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            check("busy_during_clear", 32'(if0.busy), 32'd1);
            tick();
        end
        check("busy_after_clear", 32'(if0.busy), 32'd0);

        for (int a = 0; a < DEPTH; a++) begin
            rd(AW'(a));
            check("cleared_word", if0.rdata, 32'h0);
        end

        wr(5'd3, 32'hDEADBEEF, 4'hF);
        wr(5'd3, 32'h11223344, 4'b0101);
        rd(5'd3);
        check("lane_merge", if0.rdata, 32'hDE22BE44);
        check("lane_merge_vld", 32'(if0.rvalid), 32'd1);
        tick();
        check("vld_one_pulse", 32'(if0.rvalid), 32'd0);
        check("rdata_held", if0.rdata, 32'hDE22BE44);

        ena = 1'b1; wena = 1'b1; rena = 1'b1;
        waddr = 5'd7; raddr = 5'd7; wdata = 32'hA5A5A5A5; wbe = 4'hF;
        tick();
        idle();
        check("rdw_write_first", if0.rdata, 32'hA5A5A5A5);
        check("rdw_read_first",  if1.rdata, 32'h00000000);
        rd(5'd7);
        check("rdw_rf_stored", if1.rdata, 32'hA5A5A5A5);

        ena = 1'b1; wena = 1'b1; rena = 1'b1;
        waddr = 5'd3; raddr = 5'd3; wdata = 32'h0000CC00; wbe = 4'b0010;
        tick();
        idle();
        check("rdw_partial_wf", if0.rdata, 32'hDE22CC44);
        check("rdw_partial_rf", if1.rdata, 32'hDE22BE44);

        wr(5'd9, 32'h13579BDF, 4'hF);
        ena = 1'b0; wena = 1'b1; rena = 1'b1;
        waddr = 5'd9; raddr = 5'd9; wdata = 32'hFFFFFFFF; wbe = 4'hF;
        tick();
        idle();
        check("ena0_no_rvalid", 32'(if0.rvalid), 32'd0);
        check("ena0_rdata_held", if0.rdata, 32'hDE22CC44);
        rd(5'd9);
        check("ena0_no_write", if0.rdata, 32'h13579BDF);

        ena = 1'b1; wena = 1'b1; rena = 1'b1;
        waddr = 5'd10; raddr = 5'd9; wdata = 32'hCAFEF00D; wbe = 4'hF;
        tick();
        idle();
        check("indep_read", if0.rdata, 32'h13579BDF);
        wr(5'd10, 32'h0, 4'h0);
        rd(5'd10);
        check("indep_write_wbe0", if0.rdata, 32'hCAFEF00D);

        for (int a = 0; a < DEPTH; a++) wr(AW'(a), DW'(a), 4'hF);
        for (int a = 0; a < DEPTH; a++) begin
            ena = 1'b1; rena = 1'b1; raddr = AW'(a);
            tick();
            check("b2b_rvalid", 32'(if0.rvalid), 32'd1);
            check("b2b_rdata", if0.rdata, 32'(a));
        end
        idle();

        wr(5'd31, 32'h12345678, 4'hF);
        ena = 1'b1; rena = 1'b1; raddr = 5'd31;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_drops_read", 32'(if0.rvalid), 32'd0);
        check("rst_zero_rdata", if0.rdata, 32'h0);
        ena = 1'b1; wena = 1'b1; rena = 1'b1;
        waddr = 5'd31; raddr = 5'd31; wdata = 32'hFFFFFFFF; wbe = 4'hF;
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            check("busy_after_restart", 32'(if0.busy), 32'd1);
            tick();
        end
        idle();
        check("busy_restart_done", 32'(if0.busy), 32'd0);
        rd(5'd31);
        check("restart_cleared_31", if0.rdata, 32'h0);
        rd(5'd30);
        check("restart_cleared_30", if0.rdata, 32'h0);

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/ram_dp_sync.md
RAM_DP_SYNC -- requirements
Module: ram_dp_sync

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits; must be a multiple of 8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, address width; DEPTH = 2**ADDR_WIDTH words.
REQ-003 SHALL have parameter WRITE_FIRST, default 1; 1 = read-during-write returns new data, 0 = returns old data.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port ena  input  1  block enable; when 0, no write, no read, rdata/rvalid held.
REQ-007 SHALL have port wena  input  1  write request.
REQ-008 SHALL have port waddr  input  ADDR_WIDTH  write address.
REQ-009 SHALL have port wdata  input  DATA_WIDTH  write data.
REQ-010 SHALL have port wbe  input  DATA_WIDTH/8  byte enables; bit i enables byte lane i (bits 8i+7..8i).
REQ-011 SHALL have port rena  input  1  read request.
REQ-012 SHALL have port raddr  input  ADDR_WIDTH  read address.
REQ-013 SHALL have port rdata  output  DATA_WIDTH  registered read data.
REQ-014 SHALL have port rvalid  output  1  rdata updated this cycle by an accepted read.
REQ-015 SHALL have port busy  output  1  initial clear in progress; requests ignored.

Function
REQ-016 SHALL use separate unidirectional read and write ports; no tri-state or inout bus.
REQ-017 SHALL implement FSM with states CLEAR and READY.
REQ-018 In CLEAR: write zero to mem[clr_cnt] each cycle, clr_cnt increments 0..DEPTH-1, busy=1; after writing DEPTH-1, go to READY next cycle.
REQ-019 In CLEAR: ena/wena/rena ignored; rvalid=0; rdata held at 0.
REQ-020 In READY: busy=0; write accepted when ena&wena; only lanes with wbe[i]=1 are updated; wbe=0 is a no-op.
REQ-021 Read accepted when ena&rena in READY; rdata = mem[raddr] on the next rising edge (1-cycle latency); rvalid=1 for exactly that cycle.
REQ-022 With no accepted read: rdata holds its last value; rvalid=0.
REQ-023 Simultaneous read and write, same address, WRITE_FIRST=1: rdata = enabled lanes from wdata, other lanes from old word.
REQ-024 Same case with WRITE_FIRST=0: rdata = old word, entirely.
REQ-025 Simultaneous read and write, different addresses: fully independent, no stall.
REQ-026 Addresses wrap naturally at ADDR_WIDTH bits; no out-of-range condition exists.
REQ-027 Back-to-back reads SHALL sustain one result per cycle, with rvalid continuously high.

Reset
REQ-028 rst=1 on a clock edge SHALL force: state=CLEAR, clr_cnt=0, rdata=0, rvalid=0, busy=1.
REQ-029 rst asserted mid-clear or mid-operation SHALL restart the full clear from address 0; in-flight read is discarded (rvalid=0).
REQ-030 Clear completes DEPTH cycles after the last cycle rst is sampled high; busy falls on that edge.

Structure
REQ-031 Shared package ram_pkg SHALL hold the FSM state type (CLEAR, READY) and the default width/depth constants.
REQ-032 Clear sequencing (state, clr_cnt, busy) SHALL live in sub-module ram_clear_ctrl; array, byte-lane write and read/bypass logic stay in ram_dp_sync.
REQ-033 Write port SHALL be muxed between clear (addr=clr_cnt, data=0, all lanes) and user port by state.

Verification (defaults DATA_WIDTH=32, ADDR_WIDTH=5, WRITE_FIRST=1)
REQ-034 Release rst at cycle 0 -> busy=1 for cycles 0..31, busy=0 from cycle 32; then read every address -> all rdata=0x00000000.
REQ-035 Write 0xDEADBEEF to addr 3 with wbe=4'hF, then write 0x11223344 with wbe=4'b0101, then read addr 3 -> rdata=0xDE22BE44 one cycle after rena, rvalid pulses once.
REQ-036 Same-cycle write 0xA5A5A5A5 (wbe=4'hF) and read at addr 7 holding 0x0 -> rdata=0xA5A5A5A5; rerun with WRITE_FIRST=0 -> rdata=0x00000000.
REQ-037 ena=0 with wena=rena=1 to addr 9 -> mem[9] unchanged, rvalid=0, rdata held.
REQ-038 Write 0x12345678 to addr 31, pulse rst at cycle 10 of the clear, wait -> busy high 32 cycles after the pulse; requests during busy ignored; addr 31 reads 0x0.
REQ-039 Read addrs 0..31 on consecutive cycles after writing addr=data -> rvalid high 32 consecutive cycles, rdata sequence 0..31.
